imm_extend_pipe: RTL

Parametrised, pipelined immediate extender for the out-of-order front end. It accepts a raw immediate field with a per-transaction field width, signedness and left-shift amount, and produces an OUT_W-bit extended value one cycle later. A tag rides along with each value, and a two-entry skid buffer provides full-throughput valid/ready handshaking. It sits between instruction decode and rename/issue, and replaces the fixed-width combinational extenders.

---
 rtl/imm_extend_pipe_if.sv | 35 +++
 rtl/imm_extend_pipe.sv | 110 +++++++++++
 2 files changed

// File: rtl/imm_extend_pipe_if.sv
// rtl/imm_extend_pipe_if.sv - handshake bundle for the pipelined immediate extender
//
// Carries the input channel (raw field, width, signedness, shift, tag) and
// the output channel (extended value, tag), each with valid/ready.
//   master : producer/consumer side (drives in_*, out_ready)
//   slave  : extender side (drives in_ready, out_*)
interface imm_extend_pipe_if #(
  parameter int OUT_W    = 64,
  parameter int MAX_IN_W = 26,
  parameter int WIDTH_W  = 5,
  parameter int SHIFT_W  = 2,
  parameter int TAG_W    = 6
);
  logic                in_valid;
  logic                in_ready;
  logic [MAX_IN_W-1:0] in_value;
  logic [WIDTH_W-1:0]  in_width;
  logic                in_signed;
  logic [SHIFT_W-1:0]  in_shift;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out_value;
  logic [TAG_W-1:0]    out_tag;

  modport master (
    output in_valid, in_value, in_width, in_signed, in_shift, in_tag, out_ready,
    input  in_ready, out_valid, out_value, out_tag
  );

  modport slave (
    input  in_valid, in_value, in_width, in_signed, in_shift, in_tag, out_ready,
    output in_ready, out_valid, out_value, out_tag
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - pipelined immediate extender with two-entry skid buffer
//
// Extends a raw immediate field of per-transaction width to OUT_W bits
// (sign or zero fill), shifts it left, and registers it together with a tag.
// A main register drives the output; a skid register absorbs one extra
// accepted input while the consumer stalls, so in_ready is purely registered.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears both valid bits
//   flush : synchronous; clears both valid bits and drops any input this cycle
//   bus   : imm_extend_pipe_if.slave (in_* request channel, out_* result channel)
module imm_extend_pipe #(
  parameter int OUT_W    = 64,
  parameter int MAX_IN_W = 26,
  parameter int WIDTH_W  = 5,
  parameter int SHIFT_W  = 2,
  parameter int TAG_W    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  imm_extend_pipe_if.slave bus
);

  logic [WIDTH_W-1:0] w_eff;
  logic [OUT_W-1:0]   raw_ext;
  logic [OUT_W-1:0]   keep_mask;
  logic [OUT_W-1:0]   ext_value;
  logic [OUT_W-1:0]   res_value;
  logic               sign_fill;

  // keep_mask has ones on the meaningful field bits [w-1:0]; the sign bit is
  // picked with a one-hot select so no variable-width part-select is needed.
  always_comb begin
    w_eff     = (bus.in_width > WIDTH_W'(MAX_IN_W)) ? WIDTH_W'(MAX_IN_W) : bus.in_width;
    raw_ext   = OUT_W'(bus.in_value);
    keep_mask = ~({OUT_W{1'b1}} << w_eff);
    sign_fill = bus.in_signed && (w_eff != '0) &&
                ((raw_ext & (OUT_W'(1) << (w_eff - WIDTH_W'(1)))) != '0);
    ext_value = (raw_ext & keep_mask) | (sign_fill ? ~keep_mask : '0);
    res_value = ext_value << bus.in_shift;
  end

  logic             main_valid_q, main_valid_d;
  logic [OUT_W-1:0] main_value_q, main_value_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_value_q, skid_value_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             accept;

  always_comb begin
    main_valid_d = main_valid_q;
    main_value_d = main_value_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_value_d = skid_value_q;
    skid_tag_d   = skid_tag_q;
    accept       = bus.in_valid && !skid_valid_q;

    if (!main_valid_q || bus.out_ready) begin
      // Main is free this edge: older skid entry first to keep FIFO order.
      // accept is necessarily 0 when the skid holds an entry.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_value_d = skid_value_q;
        main_tag_d   = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_value_d = res_value;
        main_tag_d   = bus.in_tag;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_value_d = res_value;
      skid_tag_d   = bus.in_tag;
    end

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Payload registers are qualified by the valid bits and need no reset.
  always_ff @(posedge clk) begin
    main_value_q <= main_value_d;
    main_tag_q   <= main_tag_d;
    skid_value_q <= skid_value_d;
    skid_tag_q   <= skid_tag_d;
  end

  assign bus.in_ready  = !skid_valid_q;
  assign bus.out_valid = main_valid_q;
  assign bus.out_value = main_value_q;
  assign bus.out_tag   = main_tag_q;

endmodule
